// File: rtl/seq_alu.sv
// Multi-cycle ALU: single-cycle logic/arithmetic ops plus iterative shift-add
// multiply and restoring divide behind a start/busy/done handshake.
module seq_alu #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       mode,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             div0,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] acc, mq, opnd;
   logic [CNT_W-1:0] cnt;
   logic             last_iter, is_mul, is_div, b_zero;
   logic             load, launch, res_div0;
   logic [WIDTH-1:0] res_c, res_hi;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] mul_acc_nxt, mul_mq_nxt, div_acc_nxt, div_mq_nxt;
   logic             div_ok;

   function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] m,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
      case (m)
         4'b0000: alu_op = a & b;
         4'b0001: alu_op = a | b;
         4'b0010: alu_op = a ^ b;
         4'b0011: alu_op = ~(a | b);
         4'b0100: alu_op = (a < b) ? WIDTH'(1) : '0;
         4'b0101: alu_op = ~(a & b);
         4'b1000: alu_op = a + b;
         4'b1001: alu_op = a - b;
         4'b1100: alu_op = a + b;
         default: alu_op = a;
      endcase
   endfunction

   assign is_mul    = (mode == 4'b1010);
   assign is_div    = (mode == 4'b1011);
   assign b_zero    = (B == '0);
   assign last_iter = (cnt == CNT_W'(WIDTH - 1));

   // acc is the running high word / partial remainder, mq the multiplier / quotient
   assign mul_sum     = {1'b0, acc} + (mq[0] ? {1'b0, opnd} : '0);
   assign mul_acc_nxt = mul_sum[WIDTH:1];
   assign mul_mq_nxt  = {mul_sum[0], mq[WIDTH-1:1]};

   assign div_shift   = {acc, mq[WIDTH-1]};
   assign div_diff    = div_shift - {1'b0, opnd};
   assign div_ok      = ~div_diff[WIDTH];
   assign div_acc_nxt = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
   assign div_mq_nxt  = {mq[WIDTH-2:0], div_ok};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (start && is_mul)                 state_nxt = S_MUL;
            else if (start && is_div && !b_zero) state_nxt = S_DIV;
         end
         S_MUL, S_DIV: if (last_iter) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load     = 1'b0;
      launch   = 1'b0;
      res_c    = '0;
      res_hi   = '0;
      res_div0 = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (is_mul || (is_div && !b_zero)) begin
                  launch = 1'b1;
               end else if (is_div) begin
                  load     = 1'b1;
                  res_c    = '1;
                  res_hi   = A;
                  res_div0 = 1'b1;
               end else begin
                  load  = 1'b1;
                  res_c = alu_op(mode, A, B);
               end
            end
         end
         S_MUL: if (last_iter) begin
            load   = 1'b1;
            res_c  = mul_mq_nxt;
            res_hi = mul_acc_nxt;
         end
         S_DIV: if (last_iter) begin
            load   = 1'b1;
            res_c  = div_mq_nxt;
            res_hi = div_acc_nxt;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         C    <= '0;
         hi   <= '0;
         zero <= 1'b0;
         div0 <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         acc  <= '0;
         mq   <= '0;
         opnd <= '0;
         cnt  <= '0;
      end else begin
         done <= load;
         busy <= (state_nxt != S_IDLE);
         if (load) begin
            C    <= res_c;
            hi   <= res_hi;
            zero <= (res_c == '0);
            div0 <= res_div0;
         end
         if (launch) begin
            acc  <= '0;
            mq   <= A;
            opnd <= B;
            cnt  <= '0;
         end else if (state == S_MUL) begin
            acc <= mul_acc_nxt;
            mq  <= mul_mq_nxt;
            cnt <= cnt + CNT_W'(1);
         end else if (state == S_DIV) begin
            acc <= div_acc_nxt;
            mq  <= div_mq_nxt;
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule
